// File: rtl/inst_dec_queue.sv
// RV32I/M decode stage: DEPTH-entry raw {inst, pc} queue feeding one registered decoded bundle.
// Optional RV32M decode is enabled by defining INST_DEC_RV32M_EN.
module inst_dec_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_inst_valid,
  output logic                       o_inst_ready,
  input  logic [31:0]                i_inst_data,
  input  logic [PC_W-1:0]            i_inst_pc,
  output logic                       o_dec_valid,
  input  logic                       i_dec_ready,
  output logic [PC_W-1:0]            o_dec_pc,
  output logic [4:0]                 o_rd,
  output logic [4:0]                 o_rs1,
  output logic [4:0]                 o_rs2,
  output logic [31:0]                o_imm,
  output logic [2:0]                 o_funct3,
  output logic [2:0]                 o_op_mode,
  output logic [2:0]                 o_func_op,
  output logic                       o_alusrc,
  output logic                       o_mem_to_reg,
  output logic                       o_reg_write,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic                       o_branch,
  output logic                       o_jump,
  output logic                       o_pc_rel,
  output logic                       o_unsigned,
  output logic                       o_ecall,
  output logic                       o_illegal,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [2:0]  op_mode;
    logic [2:0]  func_op;
    logic        alusrc;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        pc_rel;
    logic        is_unsigned;
    logic        ecall;
    logic        illegal;
  } dec_t;

  logic [31+PC_W:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              dec_valid_q, dec_valid_d;
  logic [PC_W-1:0]   dec_pc_q, dec_pc_d;
  dec_t              dec_q, dec_d, dec_n;

  logic              push, pop, bypass, q_push, load_out, q_empty, ill;
  logic [31:0]       src_inst;
  logic [PC_W-1:0]   src_pc;
  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic [31:0]       imm_i, imm_s, imm_b, imm_u, imm_j;

  assign q_empty      = (count_q == '0);
  assign o_inst_ready = (count_q < CNT_W'(DEPTH)) && !i_flush;
  assign push         = i_inst_valid && o_inst_ready;
  assign load_out     = !dec_valid_q || i_dec_ready;
  assign pop          = load_out && !q_empty;
  // Bypass only when nothing is queued ahead, so ordering is preserved.
  assign bypass       = load_out && q_empty && push;
  assign q_push       = push && !bypass;

  assign src_inst = q_empty ? i_inst_data : mem_q[rd_ptr_q][31+PC_W:PC_W];
  assign src_pc   = q_empty ? i_inst_pc   : mem_q[rd_ptr_q][PC_W-1:0];

  assign opc   = src_inst[6:0];
  assign f3    = src_inst[14:12];
  assign f7    = src_inst[31:25];
  assign imm_i = {{20{src_inst[31]}}, src_inst[31:20]};
  assign imm_s = {{20{src_inst[31]}}, src_inst[31:25], src_inst[11:7]};
  assign imm_b = {{19{src_inst[31]}}, src_inst[31], src_inst[7], src_inst[30:25], src_inst[11:8], 1'b0};
  assign imm_u = {src_inst[31:12], 12'b0};
  assign imm_j = {{11{src_inst[31]}}, src_inst[31], src_inst[19:12], src_inst[20], src_inst[30:21], 1'b0};

  always_comb begin
    dec_n        = '0;
    ill          = 1'b0;
    dec_n.funct3 = f3;
    case (opc)
      OPC_LUI: begin
        dec_n.rd = src_inst[11:7]; dec_n.imm = imm_u;
        dec_n.alusrc = 1'b1; dec_n.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_n.rd = src_inst[11:7]; dec_n.imm = imm_u; dec_n.op_mode = 3'd4;
        dec_n.alusrc = 1'b1; dec_n.reg_write = 1'b1; dec_n.pc_rel = 1'b1;
      end
      OPC_JAL: begin
        dec_n.rd = src_inst[11:7]; dec_n.imm = imm_j; dec_n.op_mode = 3'd4;
        dec_n.alusrc = 1'b1; dec_n.reg_write = 1'b1; dec_n.jump = 1'b1;
        dec_n.pc_rel = 1'b1; dec_n.branch = 1'b1;
      end
      OPC_JALR: begin
        ill = (f3 != 3'b000);
        dec_n.rd = src_inst[11:7]; dec_n.rs1 = src_inst[19:15]; dec_n.imm = imm_i;
        dec_n.op_mode = 3'd4; dec_n.alusrc = 1'b1; dec_n.reg_write = 1'b1;
        dec_n.jump = 1'b1; dec_n.branch = 1'b1;
      end
      OPC_BRANCH: begin
        dec_n.rs1 = src_inst[19:15]; dec_n.rs2 = src_inst[24:20]; dec_n.imm = imm_b;
        dec_n.op_mode = 3'd3; dec_n.branch = 1'b1;
        case (f3)
          3'b000:  dec_n.func_op = 3'b101;
          3'b001:  dec_n.func_op = 3'b100;
          3'b100:  dec_n.func_op = 3'b000;
          3'b101:  dec_n.func_op = 3'b011;
          3'b110:  begin dec_n.func_op = 3'b000; dec_n.is_unsigned = 1'b1; end
          3'b111:  begin dec_n.func_op = 3'b011; dec_n.is_unsigned = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        dec_n.rd = src_inst[11:7]; dec_n.rs1 = src_inst[19:15]; dec_n.imm = imm_i;
        dec_n.op_mode = 3'd4; dec_n.alusrc = 1'b1; dec_n.mem_to_reg = 1'b1;
        dec_n.reg_write = 1'b1; dec_n.mem_read = 1'b1;
      end
      OPC_STORE: begin
        ill = (f3[2] || f3 == 3'b011);
        dec_n.rs1 = src_inst[19:15]; dec_n.rs2 = src_inst[24:20]; dec_n.imm = imm_s;
        dec_n.op_mode = 3'd4; dec_n.alusrc = 1'b1; dec_n.mem_write = 1'b1;
      end
      OPC_OPIMM: begin
        dec_n.rd = src_inst[11:7]; dec_n.rs1 = src_inst[19:15]; dec_n.imm = imm_i;
        dec_n.alusrc = 1'b1; dec_n.reg_write = 1'b1;
        case (f3)
          3'b000: dec_n.op_mode = 3'd4;
          3'b010: dec_n.op_mode = 3'd3;
          3'b011: begin dec_n.op_mode = 3'd3; dec_n.is_unsigned = 1'b1; end
          3'b100: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b010; end
          3'b110: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b001; end
          3'b111: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b000; end
          3'b001: begin
            ill = (f7 != 7'b0000000);
            dec_n.op_mode = 3'd2; dec_n.imm = {27'b0, src_inst[24:20]};
          end
          default: begin
            ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            dec_n.op_mode = 3'd2; dec_n.imm = {27'b0, src_inst[24:20]};
            dec_n.func_op = f7[5] ? 3'b011 : 3'b010;
          end
        endcase
      end
      OPC_OP: begin
        dec_n.rd = src_inst[11:7]; dec_n.rs1 = src_inst[19:15]; dec_n.rs2 = src_inst[24:20];
        dec_n.reg_write = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec_n.op_mode = 3'd4;
            3'b001: dec_n.op_mode = 3'd2;
            3'b010: dec_n.op_mode = 3'd3;
            3'b011: begin dec_n.op_mode = 3'd3; dec_n.is_unsigned = 1'b1; end
            3'b100: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b010; end
            3'b101: begin dec_n.op_mode = 3'd2; dec_n.func_op = 3'b010; end
            3'b110: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b001; end
            default: begin dec_n.op_mode = 3'd1; dec_n.func_op = 3'b000; end
          endcase
        end else if (f7 == 7'b0100000) begin
          case (f3)
            3'b000:  begin dec_n.op_mode = 3'd4; dec_n.func_op = 3'b001; end
            3'b101:  begin dec_n.op_mode = 3'd2; dec_n.func_op = 3'b011; end
            default: ill = 1'b1;
          endcase
`ifdef INST_DEC_RV32M_EN
        end else if (f7 == 7'b0000001) begin
          // f3[2] selects divide family, f3[1] rem vs div; mul uses f3 as-is.
          if (!f3[2]) begin
            dec_n.op_mode     = 3'd5;
            dec_n.func_op     = f3;
            dec_n.is_unsigned = (f3 == 3'b011);
          end else begin
            dec_n.op_mode     = f3[1] ? 3'd7 : 3'd6;
            dec_n.func_op     = {2'b00, f3[0]};
            dec_n.is_unsigned = f3[0];
          end
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_SYSTEM: dec_n.ecall = 1'b1;
      default:    ill = 1'b1;
    endcase
    if (ill) begin
      dec_n         = '0;
      dec_n.funct3  = f3;
      dec_n.illegal = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(q_push) - CNT_W'(pop);
    dec_valid_d = dec_valid_q;
    dec_pc_d    = dec_pc_q;
    dec_d       = dec_q;
    if (q_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (load_out) begin
      dec_valid_d = pop || bypass;
      if (pop || bypass) begin
        dec_d    = dec_n;
        dec_pc_d = src_pc;
      end
    end
    if (i_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dec_valid_q <= dec_valid_d;
      dec_pc_q    <= dec_pc_d;
      dec_q       <= dec_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (q_push) mem_q[wr_ptr_q] <= {i_inst_data, i_inst_pc};
  end

  assign o_count      = count_q;
  assign o_dec_valid  = dec_valid_q;
  assign o_dec_pc     = dec_pc_q;
  assign o_rd         = dec_q.rd;
  assign o_rs1        = dec_q.rs1;
  assign o_rs2        = dec_q.rs2;
  assign o_imm        = dec_q.imm;
  assign o_funct3     = dec_q.funct3;
  assign o_op_mode    = dec_q.op_mode;
  assign o_func_op    = dec_q.func_op;
  assign o_alusrc     = dec_q.alusrc;
  assign o_mem_to_reg = dec_q.mem_to_reg;
  assign o_reg_write  = dec_q.reg_write;
  assign o_mem_read   = dec_q.mem_read;
  assign o_mem_write  = dec_q.mem_write;
  assign o_branch     = dec_q.branch;
  assign o_jump       = dec_q.jump;
  assign o_pc_rel     = dec_q.pc_rel;
  assign o_unsigned   = dec_q.is_unsigned;
  assign o_ecall      = dec_q.ecall;
  assign o_illegal    = dec_q.illegal;
endmodule

// File: tb/tb_inst_dec_queue.sv
// Scoreboard bench for inst_dec_queue: hand-encoded instructions with hand-derived decode expectations.
module tb_inst_dec_queue;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_inst_valid, i_dec_ready;
  logic        o_inst_ready, o_dec_valid;
  logic [31:0] i_inst_data, i_inst_pc, o_dec_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [2:0]  o_funct3, o_op_mode, o_func_op, o_count;
  logic        o_alusrc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write;
  logic        o_branch, o_jump, o_pc_rel, o_unsigned, o_ecall, o_illegal;

  inst_dec_queue #(.DEPTH(4), .PC_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
    .i_inst_data(i_inst_data), .i_inst_pc(i_inst_pc),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready), .o_dec_pc(o_dec_pc),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_funct3(o_funct3),
    .o_op_mode(o_op_mode), .o_func_op(o_func_op), .o_alusrc(o_alusrc),
    .o_mem_to_reg(o_mem_to_reg), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump), .o_pc_rel(o_pc_rel),
    .o_unsigned(o_unsigned), .o_ecall(o_ecall), .o_illegal(o_illegal), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // flag order: alusrc mem_to_reg reg_write mem_read mem_write branch jump pc_rel unsigned ecall illegal
  localparam logic [10:0] FA = 11'h400, FM2R = 11'h200, FRW = 11'h100, FMR = 11'h080;
  localparam logic [10:0] FMW = 11'h040, FBR = 11'h020, FJ = 11'h010, FPC = 11'h008;
  localparam logic [10:0] FU = 11'h004, FE = 11'h002, FI = 11'h001;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  op;
    logic [2:0]  fn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [10:0] fl;
  } exp_t;

  logic [31:0] tbl_inst [14];
  exp_t        tbl_exp  [14];
  exp_t        sb [$];
  int          n_total = 0, n_bad = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_pc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] inst, input logic [2:0] op,
                           input logic [2:0] fn, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [31:0] imm, input logic [10:0] fl);
    tbl_inst[i] = inst;
    tbl_exp[i]  = '{pc: 32'h0, op: op, fn: fn, rd: rd, rs1: rs1, imm: imm, fl: fl};
  endtask

  task automatic cmp_bundle(input exp_t e);
    chk("pc", o_dec_pc, e.pc);
    chk("op_mode", {29'b0, o_op_mode}, {29'b0, e.op});
    chk("func_op", {29'b0, o_func_op}, {29'b0, e.fn});
    chk("rd", {27'b0, o_rd}, {27'b0, e.rd});
    chk("rs1", {27'b0, o_rs1}, {27'b0, e.rs1});
    chk("imm", o_imm, e.imm);
    chk("flags", {21'b0, o_alusrc, o_mem_to_reg, o_reg_write, o_mem_read, o_mem_write,
                  o_branch, o_jump, o_pc_rel, o_unsigned, o_ecall, o_illegal}, {21'b0, e.fl});
  endtask

  // One cycle: drive at negedge, score consumption/acceptance, advance to next negedge.
  task automatic cyc(input logic v, input int idx, input logic [31:0] pc,
                     input logic rdy, input logic fl, output logic acc);
    exp_t e;
    if (hold_chk) begin
      chk("hold_valid", {31'b0, o_dec_valid}, 32'd1);
      chk("hold_pc", o_dec_pc, hold_pc);
    end
    i_inst_valid = v;
    i_inst_data  = tbl_inst[idx];
    i_inst_pc    = pc;
    i_dec_ready  = rdy;
    i_flush      = fl;
    #1;
    acc = v && o_inst_ready;
    if (o_dec_valid && rdy && !fl) begin
      if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        cmp_bundle(e);
      end
    end
    if (fl) sb.delete();
    if (acc) begin
      e    = tbl_exp[idx];
      e.pc = pc;
      sb.push_back(e);
    end
    hold_chk = o_dec_valid && !rdy && !fl;
    hold_pc  = o_dec_pc;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drain(input string tag);
    logic acc;
    for (int k = 0; k < 40 && sb.size() > 0; k++) cyc(1'b0, 0, 32'h0, 1'b1, 1'b0, acc);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    logic acc;
    int   sent;
    set_entry(0,  32'h00500093, 3'd4, 3'd0, 5'd1, 5'd0, 32'd5, FA | FRW);
    set_entry(1,  32'h0020E463, 3'd3, 3'd0, 5'd0, 5'd1, 32'd8, FBR | FU);
`ifdef INST_DEC_RV32M_EN
    set_entry(2,  32'h022081B3, 3'd5, 3'd0, 5'd3, 5'd1, 32'd0, FRW);
`else
    set_entry(2,  32'h022081B3, 3'd0, 3'd0, 5'd0, 5'd0, 32'd0, FI);
`endif
    set_entry(3,  32'h1234507F, 3'd0, 3'd0, 5'd0, 5'd0, 32'd0, FI);
    set_entry(4,  32'h00009067, 3'd0, 3'd0, 5'd0, 5'd0, 32'd0, FI);
    set_entry(5,  32'h123452B7, 3'd0, 3'd0, 5'd5, 5'd0, 32'h12345000, FA | FRW);
    set_entry(6,  32'h40310233, 3'd4, 3'd1, 5'd4, 5'd2, 32'd0, FRW);
    set_entry(7,  32'h4033D313, 3'd2, 3'd3, 5'd6, 5'd7, 32'd3, FA | FRW);
    set_entry(8,  32'hFFC12403, 3'd4, 3'd0, 5'd8, 5'd2, 32'hFFFFFFFC, FA | FM2R | FRW | FMR);
    set_entry(9,  32'h0050A423, 3'd4, 3'd0, 5'd0, 5'd1, 32'd8, FA | FMW);
    set_entry(10, 32'h010000EF, 3'd4, 3'd0, 5'd1, 5'd0, 32'd16, FA | FRW | FBR | FJ | FPC);
    set_entry(11, 32'h00001117, 3'd4, 3'd0, 5'd2, 5'd0, 32'h00001000, FA | FRW | FPC);
    set_entry(12, 32'h00000073, 3'd0, 3'd0, 5'd0, 5'd0, 32'd0, FE);
    set_entry(13, 32'hFFF13093, 3'd3, 3'd0, 5'd1, 5'd2, 32'hFFFFFFFF, FA | FRW | FU);

    i_rst_n = 1'b0; i_flush = 1'b0; i_inst_valid = 1'b1; i_dec_ready = 1'b1;
    i_inst_data = 32'h00500093; i_inst_pc = 32'h40;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", {31'b0, o_dec_valid}, 32'd0);
    chk("rst_count", {29'b0, o_count}, 32'd0);
    chk("rst_pc", o_dec_pc, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_rd", {27'b0, o_rd}, 32'd0);
    i_rst_n = 1'b1;

    // Single instruction into an idle stage: visible one edge later.
    cyc(1'b1, 0, 32'h100, 1'b1, 1'b0, acc);
    chk("lat_valid", {31'b0, o_dec_valid}, 32'd1);
    chk("lat_count", {29'b0, o_count}, 32'd0);
    drain("drain_single");

    // Back-to-back stream with execute always ready.
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, i, 32'h200 + 32'(4 * i), 1'b1, 1'b0, acc);
      chk("stream_acc", {31'b0, acc}, 32'd1);
    end
    chk("stream_count", {29'b0, o_count}, 32'd0);
    drain("drain_stream");

    // Stall execute, fill the queue, then release across pointer wrap.
    sent = 0;
    for (int t = 0; t < 20 && sent < 5; t++) begin
      cyc(1'b1, (sent + 5) % 14, 32'(4 * sent), 1'b0, 1'b0, acc);
      if (acc) sent++;
    end
    chk("stall_sent", sent, 5);
    chk("full_count", {29'b0, o_count}, 32'd4);
    chk("full_ready", {31'b0, o_inst_ready}, 32'd0);
    cyc(1'b1, 0, 32'h999, 1'b0, 1'b0, acc);
    chk("full_reject", {31'b0, acc}, 32'd0);
    drain("drain_full");

    // Queue three behind a held bundle, then flush with a simultaneous offer.
    sent = 0;
    for (int t = 0; t < 20 && sent < 4; t++) begin
      cyc(1'b1, sent, 32'h300 + 32'(4 * sent), 1'b0, 1'b0, acc);
      if (acc) sent++;
    end
    chk("pre_flush_count", {29'b0, o_count}, 32'd3);
    cyc(1'b1, 6, 32'h3F0, 1'b0, 1'b1, acc);
    chk("flush_push", {31'b0, acc}, 32'd0);
    chk("flush_count", {29'b0, o_count}, 32'd0);
    chk("flush_valid", {31'b0, o_dec_valid}, 32'd0);
    cyc(1'b1, 7, 32'h400, 1'b1, 1'b0, acc);
    chk("post_flush_valid", {31'b0, o_dec_valid}, 32'd1);
    drain("drain_flush");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
